// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// It owns the PC, handles stall/flush/redirect, and stops fetching on a halt opcode until a redirect.
module fetch_stage #(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       INST_W   = 16,
    parameter int unsigned       OPC_W    = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter logic [OPC_W-1:0]  HALT_OPC = {OPC_W{1'b1}},
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] iAddress,
    input  logic [INST_W-1:0] oInstruction,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] id_inst_d;
    logic [ADDR_W-1:0] id_pc_d;
    logic              id_valid_d;
    logic              halted_d;
    logic [CNT_W-1:0]  fetch_count_d;
    logic [OPC_W-1:0]  opcode;

    assign opcode   = oInstruction[INST_W-1 -: OPC_W];
    assign iAddress = pc_q;

    // Next-state and IF/ID update; priority in RUN is redirect > flush > stall > fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_inst_d     = id_inst;
        id_pc_d       = id_pc;
        id_valid_d    = id_valid;
        halted_d      = halted;
        fetch_count_d = fetch_count;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end else if (flush) begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end else if (!stall) begin
                    id_inst_d  = oInstruction;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                    if (fetch_count != {CNT_W{1'b1}}) begin
                        fetch_count_d = fetch_count + CNT_W'(1);
                    end
                    // The halt word itself is delivered; the PC parks on its address.
                    if (opcode == HALT_OPC) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                id_valid_d = 1'b0;
                id_inst_d  = NOP_INST;
                if (redirect) begin
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            id_inst     <= NOP_INST;
            id_pc       <= '0;
            id_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_inst     <= id_inst_d;
            id_pc       <= id_pc_d;
            id_valid    <= id_valid_d;
            halted      <= halted_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected outputs,
// and a negedge monitor pops and compares them. The counter is 4 bits wide so saturation is reached.
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned INST_W = 16;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              stall, flush, redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] iAddress;
    logic [INST_W-1:0] oInstruction;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              id_valid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    logic [INST_W-1:0] rom [1024];

    fetch_stage #(.ADDR_W(ADDR_W), .INST_W(INST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .iAddress(iAddress),
        .oInstruction(oInstruction), .id_inst(id_inst), .id_pc(id_pc),
        .id_valid(id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign oInstruction = rom[iAddress];

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              valid;
        logic              halt;
        logic [CNT_W-1:0]  cnt;
    } obs_t;

    obs_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference state: what the fetch stage should hold after each edge.
    int unsigned m_pc, m_idpc, m_cnt;
    logic [INST_W-1:0] m_inst;
    bit m_valid, m_halted, m_boot;

    function automatic obs_t expected();
        obs_t e;
        e.addr  = ADDR_W'(m_pc);
        e.inst  = m_inst;
        e.pc    = ADDR_W'(m_idpc);
        e.valid = m_valid;
        e.halt  = m_halted;
        e.cnt   = CNT_W'(m_cnt);
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t a;
        a.addr  = iAddress;
        a.inst  = id_inst;
        a.pc    = id_pc;
        a.valid = id_valid;
        a.halt  = halted;
        a.cnt   = fetch_count;
        return a;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_idpc = 0; m_cnt = 0; m_inst = '0;
        m_valid = 0; m_halted = 0; m_boot = 1;
    endtask

    task automatic model_edge();
        logic [INST_W-1:0] w;
        if (!reset_n) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halted) begin
            m_valid = 0;
            m_inst  = '0;
            if (redirect) begin
                m_pc     = redirect_pc;
                m_halted = 0;
            end
        end else if (redirect) begin
            m_pc    = redirect_pc;
            m_valid = 0;
            m_inst  = '0;
        end else if (flush) begin
            m_valid = 0;
            m_inst  = '0;
        end else if (!stall) begin
            w       = rom[m_pc];
            m_inst  = w;
            m_idpc  = m_pc;
            m_valid = 1;
            m_cnt   = (m_cnt >= 15) ? 15 : m_cnt + 1;
            if (w[15:10] == 6'h3F) m_halted = 1;
            else                   m_pc = (m_pc + 1) % 1024;
        end
    endtask

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got addr=%h inst=%h pc=%h v=%b h=%b cnt=%0d, want addr=%h inst=%h pc=%h v=%b h=%b cnt=%0d",
                      name, act.addr, act.inst, act.pc, act.valid, act.halt, act.cnt,
                      exp.addr, exp.inst, exp.pc, exp.valid, exp.halt, exp.cnt);
    endtask

    // Inputs are applied just after a negedge; the edge result is checked at the next negedge.
    task automatic step(input logic st, input logic fl, input logic rd, input logic [ADDR_W-1:0] rpc);
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        model_edge();
        q.push_back(expected());
        @(negedge clk);
        #1;
    endtask

    task automatic rand_step();
        logic st, fl, rd;
        rd = ($urandom_range(0, 15) == 0);
        fl = ($urandom_range(0, 7) == 0);
        st = ($urandom_range(0, 3) == 0);
        step(st, fl, rd, ADDR_W'($urandom_range(0, 1023)));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) compare("edge", observed(), q.pop_front());
    end

    initial begin
        for (int n = 0; n < 1024; n++) begin
            if (n >= 16 && n < 1000 && $urandom_range(0, 19) == 0)
                rom[n] = {6'h3F, 10'(n)};
            else if (n >= 16 && n < 1000)
                rom[n] = {6'($urandom_range(0, 62)), 10'($urandom_range(0, 1023))};
            else
                rom[n] = {6'h01, 10'(n)};
        end
        rom[7] = {6'h3F, 10'd7};

        reset_n = 1'b0; stall = 0; flush = 0; redirect = 0; redirect_pc = '0;
        model_reset();
        @(negedge clk);
        #1;
        repeat (2) step(0, 0, 0, '0);
        reset_n = 1'b1;
        step(0, 0, 0, '0);                         // boot cycle
        repeat (5) step(0, 0, 0, '0);              // fetch 0..4
        repeat (3) step(1, 0, 0, '0);              // stall at address 5
        repeat (3) step(0, 0, 0, '0);              // 5, 6, 7 (halt)
        repeat (10) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0);
        step(0, 0, 1, '0);
        repeat (3) step(0, 0, 0, '0);
        step(1, 1, 1, 10'h3F0);
        repeat (2) step(0, 0, 0, '0);
        step(0, 0, 1, 10'h3FE);
        repeat (5) step(0, 0, 0, '0);              // 3FE, 3FF, 000, 001, 002
        repeat (300) rand_step();

        // Asynchronous reset between edges.
        reset_n = 1'b0;
        #1;
        model_reset();
        compare("async_reset", observed(), expected());
        step(0, 0, 0, '0);
        reset_n = 1'b1;
        repeat (25) step(0, 0, 0, '0);
        repeat (40) rand_step();

        @(negedge clk);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
